// File: rtl/memory_access_responder.sv
// MEM-stage responder: pass-through, input-port copy, or a fixed-latency data-memory access,
// handshaked with ready/stall and a one-cycle completion pulse.
module memory_access_responder #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_BITS  = 6,
   parameter int LATENCY    = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid_In,
   input  logic                  writeEnable_In,
   input  logic [1:0]            address_Control_In,
   input  logic [DATA_WIDTH-1:0] address_In,
   input  logic [DATA_WIDTH-1:0] writeData_In,
   input  logic [DATA_WIDTH-1:0] input_Port,
   output logic                  ready_Out,
   output logic                  stall_Out,
   output logic                  resp_valid_Out,
   output logic [DATA_WIDTH-1:0] data_Out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam int         DEPTH    = 1 << ADDR_BITS;
   localparam logic [3:0] LAST_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q;
   logic [1:0]            ctrl_q;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q, inport_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  accept_s, enter_resp_s, mem_wr_s;
   logic                  eff_we_s;
   logic [1:0]            eff_ctrl_s;
   logic [DATA_WIDTH-1:0] eff_addr_s, eff_wdata_s, eff_inport_s;
   logic [ADDR_BITS-1:0]  eff_idx_s;

   // State, wait counter and result register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Request capture on acceptance
   always_ff @(posedge clock) begin
      if (reset) begin
         we_q     <= 1'b0;
         ctrl_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         inport_q <= '0;
      end else if (accept_s) begin
         we_q     <= writeEnable_In;
         ctrl_q   <= address_Control_In;
         addr_q   <= address_In;
         wdata_q  <= writeData_In;
         inport_q <= input_Port;
      end else begin
         we_q     <= we_q;
         ctrl_q   <= ctrl_q;
         addr_q   <= addr_q;
         wdata_q  <= wdata_q;
         inport_q <= inport_q;
      end
   end

   // Memory array is deliberately not cleared by reset
   always_ff @(posedge clock) begin
      if (mem_wr_s) begin
         mem_q[eff_idx_s] <= eff_wdata_s;
      end
   end

   // Effective request: live inputs when accepting straight into RESP, latched copy otherwise
   always_comb begin
      eff_we_s     = we_q;
      eff_ctrl_s   = ctrl_q;
      eff_addr_s   = addr_q;
      eff_wdata_s  = wdata_q;
      eff_inport_s = inport_q;
      if (state_q == ST_IDLE) begin
         eff_we_s     = writeEnable_In;
         eff_ctrl_s   = address_Control_In;
         eff_addr_s   = address_In;
         eff_wdata_s  = writeData_In;
         eff_inport_s = input_Port;
      end else begin
         eff_we_s     = we_q;
      end
      eff_idx_s = eff_addr_s[ADDR_BITS-1:0];
   end

   // Next-state and wait-counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 4'd0;
            if (req_valid_In) begin
               if ((address_Control_In == 2'b10) && (LATENCY != 0)) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Handshake outputs, array write strobe and result selection on the edge entering RESP
   always_comb begin
      ready_Out      = (state_q == ST_IDLE);
      resp_valid_Out = (state_q == ST_RESP);
      stall_Out      = req_valid_In && (state_q != ST_IDLE);
      accept_s       = req_valid_In && (state_q == ST_IDLE);
      enter_resp_s   = (state_d == ST_RESP) && (state_q != ST_RESP);
      mem_wr_s       = enter_resp_s && (eff_ctrl_s == 2'b10) && eff_we_s && !reset;
      data_d         = data_q;
      if (enter_resp_s) begin
         case (eff_ctrl_s)
            2'b01:   data_d = eff_inport_s;
            2'b10:   data_d = eff_we_s ? eff_wdata_s : mem_q[eff_idx_s];
            default: data_d = eff_addr_s;
         endcase
      end else begin
         data_d = data_q;
      end
   end

   assign data_Out = data_q;

endmodule

// File: tb/tb_memory_access_responder.sv
// Randomized self-checking bench for memory_access_responder against a transaction-level model.
module tb_memory_access_responder;

   localparam int DW  = 16;
   localparam int AB  = 6;
   localparam int LAT = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid_In;
   logic          writeEnable_In;
   logic [1:0]    address_Control_In;
   logic [DW-1:0] address_In, writeData_In, input_Port;
   logic          ready_Out, stall_Out, resp_valid_Out;
   logic [DW-1:0] data_Out;

   logic [DW-1:0] mem_m [1 << AB];
   int            err_cnt = 0;
   int            chk_cnt = 0;

   always #5 clock = ~clock;

   memory_access_responder #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
      .clock              (clock),
      .reset              (reset),
      .req_valid_In       (req_valid_In),
      .writeEnable_In     (writeEnable_In),
      .address_Control_In (address_Control_In),
      .address_In         (address_In),
      .writeData_In       (writeData_In),
      .input_Port         (input_Port),
      .ready_Out          (ready_Out),
      .stall_Out          (stall_Out),
      .resp_valid_Out     (resp_valid_Out),
      .data_Out           (data_Out)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected result of one transaction; updates the memory model for stores
   function automatic logic [DW-1:0] model_txn(input logic we, input logic [1:0] ctrl,
                                               input logic [DW-1:0] addr, wd, inp);
      int idx;
      idx = int'(addr) % (1 << AB);
      if (ctrl == 2'b01) return inp;
      if (ctrl == 2'b10) begin
         if (we) mem_m[idx] = wd;
         return mem_m[idx];
      end
      return addr;
   endfunction

   // Wait up to a bounded number of cycles for the response; checks latency and data
   task automatic wait_resp(input string tag, input int exp_lat, input logic [DW-1:0] exp);
      int lat;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clock);
         if (resp_valid_Out) begin
            lat = k;
            chk_eq({tag, "_data"}, data_Out, exp);
         end
      end
      chk_eq({tag, "_lat"}, lat, exp_lat);
      @(negedge clock);
      chk_eq({tag, "_pulse"}, resp_valid_Out, 1'b0);
      chk_eq({tag, "_hold"}, data_Out, exp);
   endtask

   task automatic txn(input string tag, input logic we, input logic [1:0] ctrl,
                      input logic [DW-1:0] addr, wd, inp);
      logic [DW-1:0] exp;
      exp = model_txn(we, ctrl, addr, wd, inp);
      @(negedge clock);
      chk_eq({tag, "_rdy"}, ready_Out, 1'b1);
      req_valid_In = 1'b1; writeEnable_In = we; address_Control_In = ctrl;
      address_In = addr; writeData_In = wd; input_Port = inp;
      @(posedge clock); #1;
      req_valid_In = 1'b0;
      writeEnable_In = 1'($urandom); address_Control_In = 2'($urandom);
      address_In = DW'($urandom); writeData_In = DW'($urandom); input_Port = DW'($urandom);
      wait_resp(tag, (ctrl == 2'b10) ? LAT + 1 : 1, exp);
   endtask

   initial begin
      logic [DW-1:0] exp_b;
      int            spurious;
      reset = 1'b1; req_valid_In = 1'b0; writeEnable_In = 1'b0; address_Control_In = 2'b00;
      address_In = '0; writeData_In = '0; input_Port = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_eq("rst_ready", ready_Out, 1'b1);
      chk_eq("rst_resp", resp_valid_Out, 1'b0);
      chk_eq("rst_data", data_Out, 32'h0);
      chk_eq("rst_stall", stall_Out, 1'b0);
      reset = 1'b0;

      for (int a = 0; a < (1 << AB); a++)
         txn("fill", 1'b1, 2'b10, DW'(a), DW'($urandom), DW'($urandom));

      txn("store5", 1'b1, 2'b10, 16'h0005, 16'h1234, 16'h0000);
      txn("load5", 1'b0, 2'b10, 16'h0005, 16'h0000, 16'h0000);
      txn("copy", 1'b1, 2'b01, 16'h0009, 16'h7777, 16'hBEEF);
      txn("pass", 1'b1, 2'b00, 16'hC3A5, 16'h1111, 16'h2222);
      txn("rsvd", 1'b1, 2'b11, 16'h0006, 16'h3333, 16'h4444);
      txn("wrap45", 1'b0, 2'b10, 16'h0045, 16'h0000, 16'h0000);
      txn("no_wr6", 1'b0, 2'b10, 16'h0006, 16'h0000, 16'h0000);

      // Store aborted by reset while waiting on the array
      @(negedge clock);
      req_valid_In = 1'b1; writeEnable_In = 1'b1; address_Control_In = 2'b10;
      address_In = 16'h0005; writeData_In = 16'hAAAA;
      @(posedge clock); #1;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      req_valid_In = 1'b0;
      @(negedge clock);
      chk_eq("abort_ready", ready_Out, 1'b1);
      chk_eq("abort_data", data_Out, 32'h0);
      reset = 1'b0;
      spurious = 0;
      repeat (5) begin
         @(negedge clock);
         if (resp_valid_Out) spurious++;
      end
      chk_eq("abort_noresp", spurious, 0);
      txn("abort_load5", 1'b0, 2'b10, 16'h0005, 16'h0000, 16'h0000);

      // Second request held through WAIT/RESP, then accepted once IDLE
      exp_b = model_txn(1'b1, 2'b10, 16'h0007, 16'h5A5A, 16'h0000);
      @(negedge clock);
      req_valid_In = 1'b1; writeEnable_In = 1'b1; address_Control_In = 2'b10;
      address_In = 16'h0007; writeData_In = 16'h5A5A;
      @(posedge clock); #1;
      writeEnable_In = 1'b0; address_Control_In = 2'b10; address_In = 16'h0047;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clock);
         chk_eq($sformatf("held_stall%0d", k), stall_Out, 1'b1);
      end
      chk_eq("held_resp", resp_valid_Out, 1'b1);
      chk_eq("held_data", data_Out, exp_b);
      @(negedge clock);
      chk_eq("held_stall_idle", stall_Out, 1'b0);
      chk_eq("held_ready", ready_Out, 1'b1);
      exp_b = model_txn(1'b0, 2'b10, 16'h0047, 16'h0000, 16'h0000);
      @(posedge clock); #1;
      req_valid_In = 1'b0;
      wait_resp("held_b", LAT + 1, exp_b);

      for (int n = 0; n < 60; n++)
         txn("rand", 1'($urandom), 2'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
